// File: rtl/aes_block_loader.sv
// Collects key and plaintext words for an AES-256 core. It holds the core inputs steady for
// LATENCY_P cycles, captures the ciphertext, and keeps it until downstream consumes it.
module aes_block_loader #(
  parameter int unsigned LATENCY_P = 50
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic [31:0]  word_i,
  input  logic         word_type_i,
  input  logic         v_i,
  output logic         ready_o,
  output logic [127:0] plaintext_o,
  output logic [255:0] initial_key_o,
  input  logic [127:0] ciphertext_i,
  output logic [127:0] ciphertext_o,
  output logic         v_o,
  input  logic         yumi_i,
  output logic         key_valid_o,
  output logic         err_o
);

  typedef enum logic [1:0] {StLoad, StWait, StDone} state_e;

  localparam logic [7:0] WaitInit = 8'(LATENCY_P - 1);

  state_e         state_q, state_d;
  logic [2:0]     key_cnt_q, key_cnt_d;
  logic [1:0]     pt_cnt_q, pt_cnt_d;
  logic [7:0]     wait_cnt_q, wait_cnt_d;
  logic [255:0]   key_q, key_d;
  logic [127:0]   pt_q, pt_d;
  logic [127:0]   ct_q, ct_d;
  logic           key_valid_q, key_valid_d;
  logic           err_q, err_d;
  logic           v_q, v_d;

  always_comb begin
    state_d     = state_q;
    key_cnt_d   = key_cnt_q;
    pt_cnt_d    = pt_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    key_d       = key_q;
    pt_d        = pt_q;
    ct_d        = ct_q;
    key_valid_d = key_valid_q;
    err_d       = 1'b0;
    v_d         = v_q;

    unique case (state_q)
      StLoad: begin
        if (v_i) begin
          if (!word_type_i) begin
            // Word n lands at bit (7-n)*32, so the first word is the most significant.
            key_d[{~key_cnt_q, 5'b0} +: 32] = word_i;
            if (key_cnt_q == 3'd0) key_valid_d = 1'b0;
            if (key_cnt_q == 3'd7) key_valid_d = 1'b1;
            key_cnt_d = key_cnt_q + 3'd1;
          end else if (key_valid_q) begin
            pt_d[{~pt_cnt_q, 5'b0} +: 32] = word_i;
            pt_cnt_d = pt_cnt_q + 2'd1;
            if (pt_cnt_q == 2'd3) begin
              state_d    = StWait;
              wait_cnt_d = WaitInit;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWait: begin
        if (wait_cnt_q == 8'd0) begin
          ct_d    = ciphertext_i;
          v_d     = 1'b1;
          state_d = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q - 8'd1;
        end
      end
      StDone: begin
        if (yumi_i) begin
          v_d     = 1'b0;
          state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StLoad;
      key_cnt_q   <= 3'd0;
      pt_cnt_q    <= 2'd0;
      wait_cnt_q  <= 8'd0;
      key_q       <= '0;
      pt_q        <= '0;
      ct_q        <= '0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_cnt_q   <= key_cnt_d;
      pt_cnt_q    <= pt_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      key_q       <= key_d;
      pt_q        <= pt_d;
      ct_q        <= ct_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
      v_q         <= v_d;
    end
  end

  assign ready_o       = (state_q == StLoad);
  assign plaintext_o   = pt_q;
  assign initial_key_o = key_q;
  assign ciphertext_o  = ct_q;
  assign v_o           = v_q;
  assign key_valid_o   = key_valid_q;
  assign err_o         = err_q;

endmodule
